// File: rtl/mdio_pkg.sv
// Clause-22 MDIO frame constants and FSM state encoding shared by the MDIO master.
package mdio_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, IDLE_BIT, DONE} mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  // Serial image from ST through DATA, MSB first; the TA pair is the write-frame 1,0.
  function automatic logic [31:0] mdio_frame(input logic wr, input logic [4:0] phy,
                                             input logic [4:0] regad, input logic [15:0] wdata);
    return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phy, regad, 2'b10, wdata};
  endfunction
endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: low half then high half of CLK_DIV cycles each; counter held at zero while disabled.
// slot_start marks the edge that opens the next slot (mdc falls), rise the edge where mdc goes high.
module mdio_mdc_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  output logic mdc,
  output logic slot_start,
  output logic rise
);
  localparam int CW = $clog2(2 * CLK_DIV);

  logic [CW-1:0] cnt;

  // The counter runs one behind the elapsed cycles of the slot, since the opening edge belongs to the FSM.
  assign slot_start = en && (cnt == CW'(2 * CLK_DIV - 1));
  assign rise       = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= slot_start ? '0 : cnt + 1'b1;
      if (rise)            mdc <= 1'b1;
      else if (slot_start) mdc <= 1'b0;
    end
  end
endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one register read/write per command, serialised onto MDC/MDIO.
// Response is a single-cycle pulse (P+33)*2*CLK_DIV+1 cycles after the handshake; no response backpressure.
module mdio_master #(
  parameter int CLK_DIV      = 50,
  parameter int PREAMBLE_LEN = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_hiz,
  input  logic        mdio_i
);
  import mdio_pkg::*;

  localparam logic [4:0] PRE_LAST  = (PREAMBLE_LEN > 0) ? 5'(PREAMBLE_LEN - 1) : 5'd0;
  localparam logic [4:0] HDR_LAST  = 5'(HDR_BITS - 1);
  localparam logic [4:0] TA_LAST   = 5'(TA_BITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);

  mdio_state_t state, nxt_state;
  logic [4:0]  idx, nxt_idx, pos;
  logic        wr_q, wr_sel, nxt_o, nxt_hiz;
  logic [4:0]  phy_q, reg_q;
  logic [15:0] wdata_q;
  logic [31:0] frame;
  logic [SYNC_STAGES-1:0] sync;
  logic        slot_start, rise, accept, advance;

  assign accept  = cmd_valid && cmd_ready;
  assign advance = accept || slot_start;

  mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk        (clk),
    .arst_n     (arst_n),
    .en         (state != IDLE),
    .mdc        (mdc),
    .slot_start (slot_start),
    .rise       (rise)
  );

  // Next slot's segment/index and the pad value it drives; the handshake edge opens slot 0.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx + 5'd1;
    case (state)
      IDLE:     begin nxt_state = (PREAMBLE_LEN == 0) ? HEADER : PREAMBLE; nxt_idx = '0; end
      PREAMBLE: if (idx == PRE_LAST)  begin nxt_state = HEADER;   nxt_idx = '0; end
      HEADER:   if (idx == HDR_LAST)  begin nxt_state = TA;       nxt_idx = '0; end
      TA:       if (idx == TA_LAST)   begin nxt_state = DATA;     nxt_idx = '0; end
      DATA:     if (idx == DATA_LAST) begin nxt_state = IDLE_BIT; nxt_idx = '0; end
      IDLE_BIT: begin nxt_state = DONE; nxt_idx = '0; end
      default:  begin nxt_state = IDLE; nxt_idx = '0; end
    endcase

    wr_sel = (state == IDLE) ? cmd_write : wr_q;
    frame  = (state == IDLE) ? mdio_frame(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata)
                             : mdio_frame(wr_q, phy_q, reg_q, wdata_q);
    case (nxt_state)
      HEADER:  pos = nxt_idx;
      TA:      pos = nxt_idx + 5'(HDR_BITS);
      DATA:    pos = nxt_idx + 5'(HDR_BITS + TA_BITS);
      default: pos = '0;
    endcase

    nxt_o   = 1'b1;
    nxt_hiz = 1'b1;
    case (nxt_state)
      PREAMBLE: nxt_hiz = 1'b0;
      HEADER:   begin nxt_o = frame[5'd31 - pos]; nxt_hiz = 1'b0; end
      TA, DATA: begin nxt_o = wr_sel ? frame[5'd31 - pos] : 1'b1; nxt_hiz = !wr_sel; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync <= '1;
    end else begin
      sync[0] <= mdio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_hiz  <= 1'b1;
      wr_q      <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        wr_q      <= cmd_write;
        phy_q     <= cmd_phy_addr;
        reg_q     <= cmd_reg_addr;
        wdata_q   <= cmd_wdata;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
        cmd_ready <= 1'b0;
      end
      if (advance) begin
        state    <= nxt_state;
        idx      <= nxt_idx;
        mdio_o   <= nxt_o;
        mdio_hiz <= nxt_hiz;
        if (nxt_state == DONE) rsp_valid <= 1'b1;
      end else if (state == DONE) begin
        state     <= IDLE;
        cmd_ready <= 1'b1;
      end
      // Reads sample the synchronised pad on the MDC rising edge.
      if (rise && !wr_q) begin
        if (state == TA && idx == TA_LAST) rsp_err <= sync[SYNC_STAGES-1];
        if (state == DATA) rsp_rdata <= {rsp_rdata[14:0], sync[SYNC_STAGES-1]};
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// Directed + random bench for mdio_master: decodes the MDC/MDIO waveform against a slot-list model and emulates a PHY.
module tb_mdio_master;
  localparam int D  = 4;
  localparam int PA = 32;

  logic clk = 1'b0, arst_n = 1'b0;
  logic sel = 1'b0, cmd_v = 1'b0;
  logic cmd_write = 1'b0;
  logic [4:0] cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic phy_out = 1'b1;

  logic rdy_a, rv_a, er_a, mdc_a, o_a, hiz_a;
  logic rdy_b, rv_b, er_b, mdc_b, o_b, hiz_b;
  logic [15:0] rd_a, rd_b;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PA), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .arst_n(arst_n), .cmd_valid(cmd_v && !sel), .cmd_ready(rdy_a),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(er_a),
    .mdc(mdc_a), .mdio_o(o_a), .mdio_hiz(hiz_a), .mdio_i(sel ? 1'b1 : phy_out));

  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(0), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .arst_n(arst_n), .cmd_valid(cmd_v && sel), .cmd_ready(rdy_b),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(er_b),
    .mdc(mdc_b), .mdio_o(o_b), .mdio_hiz(hiz_b), .mdio_i(sel ? phy_out : 1'b1));

  logic m_rdy, m_rv, m_err, m_mdc, m_o, m_hiz;
  logic [15:0] m_rd;
  assign m_rdy = sel ? rdy_b : rdy_a;
  assign m_rv  = sel ? rv_b  : rv_a;
  assign m_err = sel ? er_b  : er_a;
  assign m_mdc = sel ? mdc_b : mdc_a;
  assign m_o   = sel ? o_b   : o_a;
  assign m_hiz = sel ? hiz_b : hiz_a;
  assign m_rd  = sel ? rd_b  : rd_a;

  int errors = 0, checks = 0;
  logic cur_wr;
  logic [4:0] cur_phy, cur_reg;
  logic [15:0] cur_wd, phy_data;
  bit phy_en = 0, phy_dly = 0;
  bit rec_o[$], rec_hiz[$];
  int nrise = 0;
  logic prev_mdc = 1'b0, pend = 1'b1;
  bit pend_vld = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PHY: after each MDC rise it presents the value for the following slot (s = 0-based slot index).
  function automatic logic phy_val(input int s);
    int pre;
    pre = sel ? 0 : PA;
    if (!phy_en) return 1'b1;
    if (s == pre + 15) return 1'b0;
    if (s >= pre + 16 && s < pre + 32) return phy_data[31 + pre - s];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (pend_vld) begin phy_out = pend; pend_vld = 0; end
    if (!arst_n) prev_mdc = 1'b0;
    else begin
      if (m_mdc && !prev_mdc) begin
        rec_o.push_back(m_o);
        rec_hiz.push_back(m_hiz);
        nrise++;
        if (phy_dly) begin pend = phy_val(nrise); pend_vld = 1; end
        else phy_out = phy_val(nrise);
      end
      prev_mdc = m_mdc;
    end
  end

  task automatic setcmd(input logic wr, input logic [4:0] p, input logic [4:0] r, input logic [15:0] w);
    cur_wr = wr; cur_phy = p; cur_reg = r; cur_wd = w;
    cmd_write = wr; cmd_phy_addr = p; cmd_reg_addr = r; cmd_wdata = w;
  endtask

  // Called at a negedge with cmd_v already high.
  task automatic do_frame(input bit hold, output int n0, output int trsp);
    int n, pre, total, bad_o, bad_h;
    bit eo[$], eh[$], ec[$];
    logic [13:0] hdr;
    pre = sel ? 0 : PA;
    total = (pre + 33) * 2 * D;
    n = 0;
    while (!m_rdy && n < 2000) begin @(negedge clk); n++; end
    chk("handshake", m_rdy, 1);
    n0 = cyc;
    rec_o.delete(); rec_hiz.delete(); nrise = 0; phy_out = 1'b1; pend_vld = 0;
    if (!hold) begin @(posedge clk); #1 cmd_v = 1'b0; end
    n = 0;
    @(negedge clk);
    while (!m_rv && n < total + 50) begin @(negedge clk); n++; end
    trsp = cyc;
    chk("rsp_seen", m_rv, 1);
    chk("latency", trsp - n0, 1 + total);
    chk("rdata", m_rd, cur_wr ? 16'h0 : (phy_en ? phy_data : 16'hFFFF));
    chk("err", m_err, (!cur_wr && !phy_en) ? 1 : 0);
    chk("mdc_at_done", m_mdc, 0);
    @(negedge clk);
    chk("pulse_len", m_rv, 0);
    chk("ready_after", m_rdy, 1);
    chk("mdc_idle", m_mdc, 0);
    chk("rdata_hold", m_rd, cur_wr ? 16'h0 : (phy_en ? phy_data : 16'hFFFF));

    hdr = {2'b01, (cur_wr ? 2'b01 : 2'b10), cur_phy, cur_reg};
    for (int i = 0; i < pre; i++) begin eo.push_back(1); eh.push_back(0); ec.push_back(1); end
    for (int i = 13; i >= 0; i--) begin eo.push_back(hdr[i]); eh.push_back(0); ec.push_back(1); end
    for (int i = 1; i >= 0; i--) begin
      eo.push_back(i == 1); eh.push_back(!cur_wr); ec.push_back(cur_wr);
    end
    for (int i = 15; i >= 0; i--) begin
      eo.push_back(cur_wd[i]); eh.push_back(!cur_wr); ec.push_back(cur_wr);
    end
    eo.push_back(1); eh.push_back(1); ec.push_back(1);
    chk("frame_len", rec_o.size(), eo.size());
    bad_o = 0; bad_h = 0;
    for (int i = 0; i < eo.size() && i < rec_o.size(); i++) begin
      if (rec_hiz[i] !== eh[i]) bad_h++;
      if (ec[i] && rec_o[i] !== eo[i]) bad_o++;
    end
    chk("frame_mdio", bad_o, 0);
    chk("frame_hiz", bad_h, 0);
  endtask

  initial begin
    int a, b, c, d, n, pulses;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy_a, 1);
    chk("rst_rsp_valid", rv_a, 0);
    chk("rst_rdata", rd_a, 0);
    chk("rst_err", er_a, 0);
    chk("rst_mdc", mdc_a, 0);
    chk("rst_mdio_o", o_a, 1);
    chk("rst_hiz", hiz_a, 1);
    chk("rst_ready_b", rdy_b, 1);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write PHY 1 REG 0 = 0x1140
    setcmd(1'b1, 5'h01, 5'h00, 16'h1140); phy_en = 0; phy_dly = 0;
    cmd_v = 1'b1; do_frame(0, a, b);

    // Read with PHY driving 0xBEEF
    @(negedge clk);
    setcmd(1'b0, 5'h03, 5'h02, 16'h0); phy_en = 1; phy_data = 16'hBEEF;
    cmd_v = 1'b1; do_frame(0, a, b);

    // Read with no PHY present
    @(negedge clk);
    setcmd(1'b0, 5'h07, 5'h01, 16'h0); phy_en = 0;
    cmd_v = 1'b1; do_frame(0, a, b);

    // cmd_valid held across two commands
    @(negedge clk);
    setcmd(1'b1, 5'h11, 5'h1F, 16'hA55A); phy_en = 0;
    cmd_v = 1'b1; do_frame(1, a, b); do_frame(0, c, d);
    chk("b2b_gap", c - b, 1);

    // Reset in DATA slot 7 of a write
    @(negedge clk);
    setcmd(1'b1, 5'h0A, 5'h04, 16'h55AA); phy_en = 0;
    cmd_v = 1'b1;
    n = 0;
    while (!m_rdy && n < 2000) begin @(negedge clk); n++; end
    rec_o.delete(); rec_hiz.delete(); nrise = 0;
    @(posedge clk); #1 cmd_v = 1'b0;
    n = 0;
    while (nrise < PA + 24 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_data7", nrise, PA + 24);
    chk("hiz_before_rst", m_hiz, 0);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_mid_hiz", m_hiz, 1);
    chk("rst_mid_mdc", m_mdc, 0);
    chk("rst_mid_ready", m_rdy, 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    pulses = 0;
    repeat ((PA + 33) * 2 * D) begin @(negedge clk); if (m_rv) pulses++; end
    chk("no_rsp_after_rst", pulses, 0);
    setcmd(1'b1, 5'h0A, 5'h04, 16'h55AA);
    cmd_v = 1'b1; do_frame(0, a, b);

    // Random commands
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      setcmd(1'($urandom_range(1, 0)), 5'($urandom), 5'($urandom), 16'($urandom));
      phy_en = !cur_wr && ($urandom_range(3, 0) != 0);
      phy_data = 16'($urandom);
      phy_dly = 1'($urandom_range(1, 0));
      cmd_v = 1'b1; do_frame(0, a, b);
    end

    // Minimum divider, no preamble, PHY output one clk late
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    setcmd(1'b0, 5'h1C, 5'h0B, 16'h0); phy_en = 1; phy_dly = 1; phy_data = 16'hC3A5;
    cmd_v = 1'b1; do_frame(0, a, b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
IEEE 802.3 Clause-22 MDIO management master for the Ethernet PHYs. It takes single register read/write commands from the CSR side and serialises them onto MDC/MDIO. It drives the tri-stateable MDIO pad through the technology IOBUF wrapper (mdio_o -> i, mdio_hiz -> hiz, o -> mdio_i).

Parameters:
CLK_DIV, 50, clk cycles per MDC half-period; MDC period = 2*CLK_DIV; legal range >= SYNC_STAGES+2.
PREAMBLE_LEN, 32, number of preamble '1' slots; legal range 0..32.
SYNC_STAGES, 2, flops in the mdio_i synchroniser.

Ports:
clk  in  1  core clock
arst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_phy_addr  in  5  PHYAD
cmd_reg_addr  in  5  REGAD
cmd_wdata  in  16  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  16  read data (0 for writes)
rsp_err  out  1  read turnaround error (PHY did not drive TA bit 2 low)
mdc  out  1  management clock
mdio_o  out  1  to IOBUF i
mdio_hiz  out  1  to IOBUF hiz, 1=release pad
mdio_i  in  1  from IOBUF o, asynchronous

Behaviour:
- One clock; reset is asynchronous and active-low (clk, arst_n). Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_o=1, mdio_hiz=1, state=IDLE. Reset mid-frame has the same effect: the pad is released immediately and no response is issued.
- Idle: mdc held 0, mdio_hiz=1, cmd_ready=1 only in IDLE.
- Handshake cycle N0: latch all cmd fields, clear rsp_err, cmd_ready->0.
- Bit slot = 2*CLK_DIV clk cycles: low phase (mdc=0, CLK_DIV cycles) then high phase (mdc=1, CLK_DIV cycles). The first slot starts at N0+1.
- mdio_o/mdio_hiz update only on the first clk of each slot (mdc falling edge).
- Input sampling: mdio_i passes through SYNC_STAGES flops. The synchronised value is sampled on the clk where mdc goes 0->1.
- States and slot counts:
  - PREAMBLE: PREAMBLE_LEN slots, mdio_o=1, hiz=0. Skipped if PREAMBLE_LEN=0.
  - HEADER: 14 slots, MSB first: ST=01, OP (01 write, 10 read), PHYAD[4:0], REGAD[4:0]; hiz=0.
  - TA: 2 slots. Write: drive 1,0 with hiz=0. Read: hiz=1; sample in slot 2; if the sample != 0, rsp_err=1.
  - DATA: 16 slots, MSB first. Write: drive cmd_wdata with hiz=0. Read: hiz=1; shift sampled bits into rsp_rdata.
  - IDLE_BIT: 1 slot, hiz=1, mdo=1, mdc toggles normally.
  - DONE: rsp_valid=1 for exactly one cycle, then return to IDLE; cmd_ready=1 the following cycle.
- Completion timing: rsp_valid is high in cycle N0 + 1 + (PREAMBLE_LEN+33)*2*CLK_DIV. Defaults give N0+6501.
- cmd_valid held across DONE is not accepted until cmd_ready=1.
- rsp_rdata/rsp_err hold their value until the next accepted command. rsp_rdata is forced to 0 on accepted writes.
- On a read error, data is still shifted in (a floating pull-up yields 0xFFFF).
- There is no backpressure on the response; the consumer must take it on the pulse.

Decomposition:
- mdio_pkg: state enum (IDLE, PREAMBLE, HEADER, TA, DATA, IDLE_BIT, DONE), MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, HDR_BITS=14, TA_BITS=2, DATA_BITS=16.
- Sub-module mdio_mdc_gen: divider counter producing mdc, slot_start tick (falling) and rise tick; enabled only while the FSM is not IDLE, with the counter cleared when disabled.
- The frame FSM and shift registers stay in mdio_master.
- The IOBUF is instantiated at top level, not inside this block.

Test Plan:
- Write, CLK_DIV=4: PHY 5'h01, REG 5'h00, data 16'h1140 -> decoded frame = 32 ones, 01 01 00001 00000 10, 0001000101000000; hiz=0 throughout except IDLE_BIT; rsp_valid at N0+1+65*8=N0+521; rsp_err=0.
- Read with PHY model: PHY 5'h03, REG 5'h02, model drives TA2=0 and data 16'hBEEF after mdc rise -> rsp_rdata=16'hBEEF, rsp_err=0, hiz=1 from first TA slot.
- Read, no PHY (mdio_i tied 1) -> rsp_err=1, rsp_rdata=16'hFFFF.
- cmd_valid held high for two commands -> second handshake occurs exactly 1 cycle after the first rsp_valid; mdc stays 0 between frames.
- arst_n pulsed low in DATA slot 7 of a write -> within the same cycle mdio_hiz=1, mdc=0; no rsp_valid; next command completes normally.
- CLK_DIV=SYNC_STAGES+2=4, PREAMBLE_LEN=0 read -> correct data with PHY output delay of 1 clk; rsp_valid at N0+1+33*8.
